pid_chn_scheduler: RTL and testbench

Parametrised successor to the fixed four-channel front end of the motor-control top level. It collects per-channel RPM samples from `NUM_CHN` readers and per-channel speed references written over the UART path. It then round-robin schedules them, one transfer at a time, into the shared 3p3z PID core through a valid/ready handshake. It also reports per-channel sample overrun and encoder-stale status.

---
 rtl/pid_chn_scheduler.sv | 165 ++++++++++++++++
 tb/tb_pid_chn_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_chn_scheduler.sv
// Per-channel RPM/reference front end feeding one shared PID core.
// Channels are served round-robin, one valid/ready transfer at a time.

module pid_chn_lane #(
    parameter int DATA_WIDTH  = 16,
    parameter int STALE_LIMIT = 2000000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_smp,
    input  logic [DATA_WIDTH-1:0] i_smp_data,
    input  logic                  i_gnt,
    input  logic                  i_ref_we,
    input  logic [DATA_WIDTH-1:0] i_ref_data,
    input  logic                  i_clr,
    output logic [DATA_WIDTH-1:0] o_fdb,
    output logic [DATA_WIDTH-1:0] o_ref,
    output logic                  o_pending,
    output logic                  o_overrun,
    output logic                  o_stale
);
    localparam int CNT_W = $clog2(STALE_LIMIT + 1);

    logic [DATA_WIDTH-1:0] r_fdb, r_ref;
    logic                  r_pending, r_overrun, r_stale;
    logic [CNT_W-1:0]      r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fdb     <= '0;
            r_ref     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_stale   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (i_smp) r_fdb <= i_smp_data;
            if (i_ref_we) r_ref <= i_ref_data;
            // a sample landing in the grant cycle re-arms pending without counting as overrun
            if (i_smp) r_pending <= 1'b1;
            else if (i_gnt) r_pending <= 1'b0;
            if (i_smp && r_pending && !i_gnt) r_overrun <= 1'b1;
            else if (i_clr) r_overrun <= 1'b0;
            if (i_smp) r_cnt <= '0;
            else if (r_cnt != CNT_W'(STALE_LIMIT)) r_cnt <= r_cnt + CNT_W'(1);
            r_stale <= (r_cnt == CNT_W'(STALE_LIMIT));
        end
    end

    assign o_fdb     = r_fdb;
    assign o_ref     = r_ref;
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;
    assign o_stale   = r_stale;
endmodule

module pid_chn_scheduler #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CHN     = 4,
    parameter int CHN_WIDTH   = 3,
    parameter int STALE_LIMIT = 2000000
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_CHN-1:0]            rpm_valid_i,
    input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data_i,
    input  logic                          ref_valid_i,
    input  logic [CHN_WIDTH-1:0]          ref_chn_i,
    input  logic [DATA_WIDTH-1:0]         ref_data_i,
    input  logic                          clr_flags_i,
    output logic                          data_valid_o,
    output logic [CHN_WIDTH-1:0]          data_chn_o,
    output logic [DATA_WIDTH-1:0]         data_fdb_o,
    output logic [DATA_WIDTH-1:0]         data_ref_o,
    input  logic                          tready_i,
    output logic [NUM_CHN-1:0]            overrun_o,
    output logic [NUM_CHN-1:0]            stale_o
);
    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                               r_state, w_state_nxt;
    logic [CHN_WIDTH-1:0]                 r_last;
    logic [NUM_CHN-1:0][DATA_WIDTH-1:0]   w_fdb, w_ref;
    logic [NUM_CHN-1:0]                   w_pending, w_overrun, w_stale;
    logic [NUM_CHN-1:0]                   w_gnt_oh;
    logic [CHN_WIDTH-1:0]                 w_gnt_idx;
    logic [DATA_WIDTH-1:0]                w_gnt_fdb, w_gnt_ref;
    logic                                 w_grant;

    for (genvar k = 0; k < NUM_CHN; k++) begin : g_lane
        pid_chn_lane #(.DATA_WIDTH(DATA_WIDTH), .STALE_LIMIT(STALE_LIMIT)) u_lane (
            .clk        (clk),
            .rstn       (rstn),
            .i_smp      (rpm_valid_i[k]),
            .i_smp_data (rpm_data_i[k*DATA_WIDTH +: DATA_WIDTH]),
            .i_gnt      (w_grant & w_gnt_oh[k]),
            .i_ref_we   (ref_valid_i && (ref_chn_i == CHN_WIDTH'(k))),
            .i_ref_data (ref_data_i),
            .i_clr      (clr_flags_i),
            .o_fdb      (w_fdb[k]),
            .o_ref      (w_ref[k]),
            .o_pending  (w_pending[k]),
            .o_overrun  (w_overrun[k]),
            .o_stale    (w_stale[k])
        );
    end

    // Walk distances from the farthest down to 1 so the closest pending channel after r_last wins.
    always_comb begin
        w_gnt_oh  = '0;
        w_gnt_idx = '0;
        w_gnt_fdb = '0;
        w_gnt_ref = '0;
        for (int i = NUM_CHN; i >= 1; i--) begin
            for (int k = 0; k < NUM_CHN; k++) begin
                if (w_pending[k] && ((int'(r_last) + i == k) || (int'(r_last) + i == k + NUM_CHN))) begin
                    w_gnt_oh    = '0;
                    w_gnt_oh[k] = 1'b1;
                    w_gnt_idx   = CHN_WIDTH'(k);
                end
            end
        end
        for (int k = 0; k < NUM_CHN; k++) begin
            w_gnt_fdb = w_gnt_fdb | (w_fdb[k] & {DATA_WIDTH{w_gnt_oh[k]}});
            w_gnt_ref = w_gnt_ref | (w_ref[k] & {DATA_WIDTH{w_gnt_oh[k]}});
        end
    end

    assign w_grant = (r_state == S_IDLE) && (|w_pending);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|w_pending) w_state_nxt = S_SEND;
            S_SEND:  if (tready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_valid_o <= 1'b0;
            data_chn_o   <= '0;
            data_fdb_o   <= '0;
            data_ref_o   <= '0;
            r_last       <= CHN_WIDTH'(NUM_CHN - 1);
        end else if (w_grant) begin
            data_valid_o <= 1'b1;
            data_chn_o   <= w_gnt_idx;
            data_fdb_o   <= w_gnt_fdb;
            data_ref_o   <= w_gnt_ref;
            r_last       <= w_gnt_idx;
        end else if (r_state == S_SEND && tready_i) begin
            data_valid_o <= 1'b0;
        end
    end

    assign overrun_o = w_overrun;
    assign stale_o   = w_stale;
endmodule

// File: tb/tb_pid_chn_scheduler.sv
// Scoreboard bench: stimulus queues expected transfers, a negedge monitor pops and compares on handshake.

module tb_pid_chn_scheduler;
    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  rpm_valid;
    logic [63:0] rpm_data;
    logic        ref_valid;
    logic [2:0]  ref_chn;
    logic [15:0] ref_data;
    logic        clr_flags;
    logic        tready;
    logic        data_valid_o;
    logic [2:0]  data_chn_o;
    logic [15:0] data_fdb_o, data_ref_o;
    logic [3:0]  overrun_o, stale_o;

    typedef struct {
        logic [2:0]  chn;
        logic [15:0] fdb;
        logic [15:0] rf;
        int          ecyc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    pid_chn_scheduler #(.DATA_WIDTH(16), .NUM_CHN(4), .CHN_WIDTH(3), .STALE_LIMIT(10)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rpm_valid_i  (rpm_valid),
        .rpm_data_i   (rpm_data),
        .ref_valid_i  (ref_valid),
        .ref_chn_i    (ref_chn),
        .ref_data_i   (ref_data),
        .clr_flags_i  (clr_flags),
        .data_valid_o (data_valid_o),
        .data_chn_o   (data_chn_o),
        .data_fdb_o   (data_fdb_o),
        .data_ref_o   (data_ref_o),
        .tready_i     (tready),
        .overrun_o    (overrun_o),
        .stale_o      (stale_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks each handshake against the queue and that stalled transfers stay frozen.
    logic        hold = 1'b0;
    logic [2:0]  h_chn;
    logic [15:0] h_fdb, h_ref;
    always @(negedge clk) begin
        if (!rstn) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                n_cmp++;
                if (!(data_valid_o && data_chn_o == h_chn && data_fdb_o == h_fdb && data_ref_o == h_ref)) begin
                    n_err++;
                    $display("FAIL hold: got v=%b chn=%0d fdb=%h ref=%h, required v=1 chn=%0d fdb=%h ref=%h",
                             data_valid_o, data_chn_o, data_fdb_o, data_ref_o, h_chn, h_fdb, h_ref);
                end
            end
            if (data_valid_o && tready) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL xfer: unexpected transfer chn=%0d fdb=%h ref=%h at cyc %0d, required none",
                             data_chn_o, data_fdb_o, data_ref_o, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (data_chn_o != e.chn || data_fdb_o != e.fdb || data_ref_o != e.rf ||
                        (e.ecyc >= 0 && e.ecyc != cyc)) begin
                        n_err++;
                        $display("FAIL xfer: got chn=%0d fdb=%h ref=%h cyc=%0d, required chn=%0d fdb=%h ref=%h cyc=%0d",
                                 data_chn_o, data_fdb_o, data_ref_o, cyc, e.chn, e.fdb, e.rf, e.ecyc);
                    end
                end
            end
            hold  = data_valid_o && !tready;
            h_chn = data_chn_o;
            h_fdb = data_fdb_o;
            h_ref = data_ref_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic push(input logic [2:0] c, input logic [15:0] f, input logic [15:0] r, input int ec);
        exp_t e;
        e.chn = c; e.fdb = f; e.rf = r; e.ecyc = ec;
        sbq.push_back(e);
    endtask

    task automatic rpm(input int k, input logic [15:0] d);
        rpm_valid[k]        = 1'b1;
        rpm_data[k*16 +: 16] = d;
    endtask

    task automatic refw(input logic [2:0] c, input logic [15:0] d);
        ref_valid = 1'b1;
        ref_chn   = c;
        ref_data  = d;
    endtask

    task automatic idle_in();
        rpm_valid = '0;
        ref_valid = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && sbq.size() != 0; i++) tick();
        tick();
        tick();
        chk(nm, sbq.size(), 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        int c;
        logic seen;
        rstn = 1'b0; tready = 1'b1; rpm_data = '0; ref_chn = '0; ref_data = '0;
        idle_in();
        tick(); tick();
        chk("rst_valid", data_valid_o, 0);
        chk("rst_data", {data_fdb_o, data_ref_o}, 0);
        chk("rst_flags", {overrun_o, stale_o, data_chn_o}, 0);
        rstn = 1'b1;
        tick();

        // single sample, ref written first
        refw(3'd2, 16'h0100); tick(); idle_in();
        rpm(2, 16'h0050); push(3'd2, 16'h0050, 16'h0100, cyc + 2); tick(); idle_in();
        tick(); tick();
        chk("t1_one_cycle", data_valid_o, 0);
        drain("t1_drain");

        // round-robin from reset pointer
        do_reset();
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            rpm(k, 16'h00A0 + 16'(k));
            push(3'(k), 16'h00A0 + 16'(k), 16'h0000, c + 2 + 2*k);
        end
        tick(); idle_in();
        drain("t2_drain");
        chk("t2_overrun", overrun_o, 0);

        // backpressure, overrun, clear-vs-set
        tready = 1'b0;
        refw(3'd1, 16'h1111); tick(); refw(3'd3, 16'h3333); tick(); idle_in();
        rpm(1, 16'h0011); push(3'd1, 16'h0011, 16'h1111, -1); tick(); idle_in(); tick();
        chk("t3_granted", {data_valid_o, data_chn_o}, {1'b1, 3'd1});
        refw(3'd1, 16'h2222); tick(); idle_in();
        rpm(3, 16'h0033); tick(); rpm(3, 16'h0034); tick(); idle_in(); tick();
        chk("t3_overrun", overrun_o, 4'b1000);
        rpm(2, 16'h0021); tick(); rpm(2, 16'h0022); clr_flags = 1'b1; tick(); idle_in(); tick();
        chk("t3_clr_vs_set", overrun_o, 4'b0100);
        chk("t3_still_held", {data_valid_o, data_chn_o}, {1'b1, 3'd1});
        push(3'd2, 16'h0022, 16'h0000, -1);
        push(3'd3, 16'h0034, 16'h3333, -1);
        tready = 1'b1;
        drain("t3_drain");
        clr_flags = 1'b1; tick(); clr_flags = 1'b0; tick();
        chk("t3_cleared", overrun_o, 0);

        // sample arrives in ch0's grant cycle; ref written alongside first sample
        refw(3'd0, 16'h0FAB); rpm(0, 16'h000A); push(3'd0, 16'h000A, 16'h0FAB, cyc + 2); tick();
        ref_valid = 1'b0; rpm(0, 16'h000B); push(3'd0, 16'h000B, 16'h0FAB, cyc + 3); tick(); idle_in();
        drain("t4_drain");
        chk("t4_overrun", overrun_o, 0);

        // stale timing on ch1
        c = cyc;
        rpm(1, 16'h5151); push(3'd1, 16'h5151, 16'h2222, c + 2); tick(); idle_in();
        while (cyc < c + 11) tick();
        chk("t5_not_yet", stale_o[1], 0);
        tick();
        chk("t5_stale", stale_o[1], 1);
        rpm(1, 16'h5252); push(3'd1, 16'h5252, 16'h2222, cyc + 2); tick(); idle_in();
        chk("t5_stale_hold", stale_o[1], 1);
        tick();
        chk("t5_stale_clr", stale_o[1], 0);
        refw(3'd5, 16'hDEAD); tick(); idle_in();
        drain("t5_drain");
        // pointer sits at ch1, so service wraps 2,3,0,1; refs must be untouched by the ch5 write
        for (int k = 0; k < 4; k++) rpm(k, 16'h00B0 + 16'(k));
        push(3'd2, 16'h00B2, 16'h0000, -1);
        push(3'd3, 16'h00B3, 16'h3333, -1);
        push(3'd0, 16'h00B0, 16'h0FAB, -1);
        push(3'd1, 16'h00B1, 16'h2222, -1);
        tick(); idle_in();
        drain("t5_rr_drain");

        // reset during SEND
        tready = 1'b0;
        rpm(2, 16'h00C2); tick(); idle_in(); tick();
        chk("t6_busy", {data_valid_o, data_chn_o}, {1'b1, 3'd2});
        rpm(3, 16'h00C3); tick(); idle_in();
        rstn = 1'b0;
        #1;
        chk("t6_async_drop", data_valid_o, 0);
        tick();
        rstn = 1'b1; tready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (data_valid_o) seen = 1'b1;
        end
        chk("t6_no_xfer", seen, 0);
        rpm(3, 16'h00C4); push(3'd3, 16'h00C4, 16'h0000, cyc + 2); tick(); idle_in();
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
